// File: rtl/if_stage_pc_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : if_stage_pc_reg                                               |
// | Description : Fetch-stage PC register and IF/ID pipeline register with      |
// |               stall, exception flush, eret squash and fetch fault detection.|
// |               Optional perf counters enabled by macro IF_PERF_CNT_EN.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module if_stage_pc_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_LAST   = 32'h0000_6FFC,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_PC,
    input  logic [31:0] InstrF,
    input  logic        stall,
    input  logic        Req,
    input  logic        eretD,
    input  logic        BDIn,
    output logic [31:0] PCF,
    output logic [31:0] PCD,
    output logic [31:0] InstrD,
    output logic        BDD,
    output logic [4:0]  ExcCodeD
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [4:0]  c_EXC_NONE = 5'd0;
    localparam logic [4:0]  c_EXC_ADEL = 5'd4;
    localparam logic [31:0] c_NOP      = 32'h0000_0000;

    logic [31:0] r_pcf;
    logic [31:0] r_pcd;
    logic [31:0] r_instr_d;
    logic        r_bd_d;
    logic [4:0]  r_exc_d;

    logic [31:0] w_pcf_nxt;
    logic [31:0] w_pcd_nxt;
    logic [31:0] w_instr_d_nxt;
    logic        w_bd_d_nxt;
    logic [4:0]  w_exc_d_nxt;
    logic        w_fault;

    // Misaligned or outside the instruction memory window raises AdEL.
    assign w_fault = (r_pcf[1:0] != 2'b00) || (r_pcf < IM_BASE) || (r_pcf > IM_LAST);

    always_comb begin
        w_pcf_nxt     = r_pcf;
        w_pcd_nxt     = r_pcd;
        w_instr_d_nxt = r_instr_d;
        w_bd_d_nxt    = r_bd_d;
        w_exc_d_nxt   = r_exc_d;
        if (Req) begin
            w_pcf_nxt     = next_PC;
            w_pcd_nxt     = EXC_ENTRY;
            w_instr_d_nxt = c_NOP;
            w_bd_d_nxt    = 1'b0;
            w_exc_d_nxt   = c_EXC_NONE;
        end else if (stall) begin
            // Hold everything; a pending eret is picked up once the stall drops.
            w_pcf_nxt     = r_pcf;
        end else if (eretD) begin
            w_pcf_nxt     = next_PC;
            w_pcd_nxt     = r_pcf;
            w_instr_d_nxt = c_NOP;
            w_bd_d_nxt    = 1'b0;
            w_exc_d_nxt   = c_EXC_NONE;
        end else begin
            w_pcf_nxt     = next_PC;
            w_pcd_nxt     = r_pcf;
            w_bd_d_nxt    = BDIn;
            w_instr_d_nxt = w_fault ? c_NOP : InstrF;
            w_exc_d_nxt   = w_fault ? c_EXC_ADEL : c_EXC_NONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcf     <= RESET_PC;
            r_pcd     <= 32'h0000_0000;
            r_instr_d <= c_NOP;
            r_bd_d    <= 1'b0;
            r_exc_d   <= c_EXC_NONE;
        end else begin
            r_pcf     <= w_pcf_nxt;
            r_pcd     <= w_pcd_nxt;
            r_instr_d <= w_instr_d_nxt;
            r_bd_d    <= w_bd_d_nxt;
            r_exc_d   <= w_exc_d_nxt;
        end
    end

    assign PCF      = r_pcf;
    assign PCD      = r_pcd;
    assign InstrD   = r_instr_d;
    assign BDD      = r_bd_d;
    assign ExcCodeD = r_exc_d;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_evt;

    assign w_stall_evt = stall & ~Req;
    assign w_flush_evt = Req | (eretD & ~stall);

    // Counters saturate instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 32'h0000_0000;
            r_flush_cnt <= 32'h0000_0000;
        end else begin
            if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush_evt && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage_pc_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_if_stage_pc_reg                                            |
// | Description : Self-checking bench for if_stage_pc_reg (directed + random).  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_if_stage_pc_reg;

    logic        clk;
    logic        reset;
    logic [31:0] next_PC;
    logic [31:0] InstrF;
    logic        stall;
    logic        Req;
    logic        eretD;
    logic        BDIn;
    logic [31:0] PCF;
    logic [31:0] PCD;
    logic [31:0] InstrD;
    logic        BDD;
    logic [4:0]  ExcCodeD;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 0;

    if_stage_pc_reg dut (
        .clk      (clk),
        .reset    (reset),
        .next_PC  (next_PC),
        .InstrF   (InstrF),
        .stall    (stall),
        .Req      (Req),
        .eretD    (eretD),
        .BDIn     (BDIn),
        .PCF      (PCF),
        .PCD      (PCD),
        .InstrD   (InstrD),
        .BDD      (BDD),
        .ExcCodeD (ExcCodeD)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state of the fetch stage.
    logic [31:0] m_pcf, m_pcd, m_instr;
    logic        m_bdd;
    logic [4:0]  m_exc;
    longint      m_stall_n, m_flush_n;

    function automatic bit bad_fetch(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pcf = 32'h3000; m_pcd = 0; m_instr = 0; m_bdd = 0; m_exc = 0;
            m_stall_n = 0; m_flush_n = 0;
        end else begin
            if (stall && !Req) m_stall_n++;
            if (Req || (eretD && !stall)) m_flush_n++;
            if (Req) begin
                m_pcd = 32'h4180; m_instr = 0; m_bdd = 0; m_exc = 0;
                m_pcf = next_PC;
            end else if (!stall) begin
                if (eretD) begin
                    m_pcd = m_pcf; m_instr = 0; m_bdd = 0; m_exc = 0;
                end else begin
                    m_pcd   = m_pcf;
                    m_bdd   = BDIn;
                    m_instr = bad_fetch(m_pcf) ? 32'h0 : InstrF;
                    m_exc   = bad_fetch(m_pcf) ? 5'd4 : 5'd0;
                end
                m_pcf = next_PC;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model PCF", PCF, m_pcf);
            chk("model PCD", PCD, m_pcd);
            chk("model InstrD", InstrD, m_instr);
            chk("model BDD", {31'd0, BDD}, {31'd0, m_bdd});
            chk("model ExcCodeD", {27'd0, ExcCodeD}, {27'd0, m_exc});
`ifdef IF_PERF_CNT_EN
            chk("model stall_cnt", stall_cnt, 32'(m_stall_n));
            chk("model flush_cnt", flush_cnt, 32'(m_flush_n));
`endif
        end
    end

    function automatic logic [31:0] tag(input logic [31:0] pc);
        return 32'hAB00_0000 | pc;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] npc, input logic [31:0] ins,
                         input logic st, input logic rq, input logic er, input logic bd);
        next_PC = npc; InstrF = ins; stall = st; Req = rq; eretD = er; BDIn = bd;
    endtask

    task automatic chk_all(input string nm, input logic [31:0] pcf, input logic [31:0] pcd,
                           input logic [31:0] ins, input logic bd, input logic [4:0] ex);
        chk({nm, " PCF"}, PCF, pcf);
        chk({nm, " PCD"}, PCD, pcd);
        chk({nm, " InstrD"}, InstrD, ins);
        chk({nm, " BDD"}, {31'd0, BDD}, {31'd0, bd});
        chk({nm, " ExcCodeD"}, {27'd0, ExcCodeD}, {27'd0, ex});
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk_all("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 5'd0);
        reset = 1'b0;
        chk_en = 1;

        // Sequential fetch
        drive(32'h3004, tag(32'h3000), 0, 0, 0, 0); cyc();
        chk_all("seq1", 32'h3004, 32'h3000, 32'hAB00_3000, 0, 0);
        drive(32'h3008, tag(32'h3004), 0, 0, 0, 0); cyc();
        chk_all("seq2", 32'h3008, 32'h3004, 32'hAB00_3004, 0, 0);

        // Stall holds everything
        drive(32'h5000, 32'hDEAD_BEEF, 1, 0, 0, 1); cyc(); cyc();
        chk_all("stall", 32'h3008, 32'h3004, 32'hAB00_3004, 0, 0);
        drive(32'h300C, tag(32'h3008), 0, 0, 0, 0); cyc();
        chk_all("unstall", 32'h300C, 32'h3008, 32'hAB00_3008, 0, 0);

        // Req beats stall and eret
        drive(32'h4180, 32'h1234_5678, 1, 1, 1, 1); cyc();
        chk_all("req", 32'h4180, 32'h4180, 32'h0, 0, 0);

        // eret held by stall, then honoured
        drive(32'h3108, tag(32'h4180), 0, 0, 0, 0); cyc();
        drive(32'h3104, 32'h1111_1111, 1, 0, 1, 0); cyc();
        chk_all("eret stalled", 32'h3108, 32'h4180, 32'hAB00_4180, 0, 0);
        drive(32'h3104, 32'h1111_1111, 0, 0, 1, 1); cyc();
        chk_all("eret", 32'h3104, 32'h3108, 32'h0, 0, 0);

        // Fetch faults and boundaries
        drive(32'h3002, tag(32'h3104), 0, 0, 0, 0); cyc();
        drive(32'h7000, tag(32'h3002), 0, 0, 0, 0); cyc();
        chk_all("misalign", 32'h7000, 32'h3002, 32'h0, 0, 5'd4);
        drive(32'h6FFC, tag(32'h7000), 0, 0, 0, 0); cyc();
        chk_all("above", 32'h6FFC, 32'h7000, 32'h0, 0, 5'd4);
        drive(32'h2FFC, tag(32'h6FFC), 0, 0, 0, 0); cyc();
        chk_all("top edge", 32'h2FFC, 32'h6FFC, 32'hAB00_6FFC, 0, 0);
        drive(32'h3000, tag(32'h2FFC), 0, 0, 0, 0); cyc();
        chk_all("below", 32'h3000, 32'h2FFC, 32'h0, 0, 5'd4);
        drive(32'h3004, tag(32'h3000), 0, 0, 0, 1); cyc();
        chk_all("delay slot", 32'h3004, 32'h3000, 32'hAB00_3000, 1, 0);

        // Async reset mid-stall
        drive(32'h3008, tag(32'h3004), 1, 0, 0, 0); cyc();
        reset = 1'b1; #1;
        chk_all("async reset", 32'h3000, 32'h0, 32'h0, 0, 0);
        #1 reset = 1'b0;
        drive(32'h3004, tag(32'h3000), 0, 0, 0, 0); cyc();
        chk_all("post reset", 32'h3004, 32'h3000, 32'hAB00_3000, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] npc;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: npc = m_pcf + 32'd4;
                6: npc = 32'h3000 + ($urandom_range(0, 4095) << 2);
                7: case ($urandom_range(0, 3))
                       0: npc = 32'h2FFC;
                       1: npc = 32'h3000;
                       2: npc = 32'h6FFC;
                       default: npc = 32'h7000;
                   endcase
                8: npc = $urandom;
                default: npc = 32'h4180;
            endcase
            drive(npc, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1; #1 reset = 1'b0;
            end
            cyc();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
